// File: rtl/proj1_ctrl_if.sv
// Control/status bundle between the sequencer and the accumulator datapath.
// master = control unit, slave = datapath (register bank, RAM, divider).
interface proj1_ctrl_if;
    logic [3:0] opcode;
    logic       zflag;
    logic       div_done;
    logic       pc_inc;
    logic       pc_load;
    logic       ir_load;
    logic       mar_load;
    logic       mar_src;
    logic       mdr_load;
    logic       mdr_src;
    logic       acc_load;
    logic [2:0] alu_op;
    logic       mem_we;
    logic       div_load;

    modport master (
        input  opcode, zflag, div_done,
        output pc_inc, pc_load, ir_load, mar_load, mar_src, mdr_load, mdr_src,
               acc_load, alu_op, mem_we, div_load
    );

    modport slave (
        output opcode, zflag, div_done,
        input  pc_inc, pc_load, ir_load, mar_load, mar_src, mdr_load, mdr_src,
               acc_load, alu_op, mem_we, div_load
    );
endinterface

// File: rtl/proj1_ctrl.sv
// Moore sequencer for the accumulator machine: fetch/decode/execute, RAM store
// path and a timeout-guarded handshake with the iterative divider.
module proj1_ctrl #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    proj1_ctrl_if.master     dp,
    input  logic             run,
    output logic             halted,
    output logic             illegal,
    output logic             div_err,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH1    = 4'd0,
        S_FETCH2    = 4'd1,
        S_FETCH3    = 4'd2,
        S_DECODE    = 4'd3,
        S_MEMRD     = 4'd4,
        S_EXEC      = 4'd5,
        S_ST1       = 4'd6,
        S_ST2       = 4'd7,
        S_DIV_START = 4'd8,
        S_DIV_WAIT  = 4'd9,
        S_HALT      = 4'd10
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_DIV   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;
    localparam logic [2:0] ALU_DIVQ = 3'd6;

    localparam logic [7:0] TMO_LAST = 8'(DIV_TIMEOUT - 1);

    state_t     state;
    logic [7:0] tcnt;
    logic       div_seen;

    // The divider clears Done on the edge it takes Load, so the first wait
    // cycle (tcnt == 0) may still show a stale Done and is ignored.
    assign div_seen = (tcnt != 8'd0) && dp.div_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH1;
            instr_count <= '0;
            illegal     <= 1'b0;
            div_err     <= 1'b0;
            tcnt        <= '0;
        end else begin
            case (state)
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: state <= S_FETCH3;
                S_FETCH3: begin
                    instr_count <= instr_count + 1'b1;
                    state       <= S_DECODE;
                end
                S_DECODE: begin
                    case (dp.opcode)
                        OP_NOP, OP_NOT, OP_JMP, OP_JZ:                 state <= S_FETCH1;
                        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_DIV: state <= S_MEMRD;
                        OP_STORE:                                      state <= S_ST1;
                        OP_HALT:                                       state <= S_HALT;
                        default: begin
                            illegal <= 1'b1;
                            state   <= S_HALT;
                        end
                    endcase
                end
                S_MEMRD:     state <= (dp.opcode == OP_DIV) ? S_DIV_START : S_EXEC;
                S_EXEC:      state <= S_FETCH1;
                S_ST1:       state <= S_ST2;
                S_ST2:       state <= S_FETCH1;
                S_DIV_START: begin
                    tcnt  <= '0;
                    state <= S_DIV_WAIT;
                end
                S_DIV_WAIT: begin
                    if (div_seen) begin
                        state <= S_FETCH1;
                    end else if (tcnt == TMO_LAST) begin
                        div_err <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_HALT: begin
                    if (run) begin
                        illegal <= 1'b0;
                        div_err <= 1'b0;
                        state   <= S_FETCH1;
                    end
                end
                default: state <= S_FETCH1;
            endcase
        end
    end

    // Strobes follow the current state; held quiet while reset is asserted.
    always_comb begin
        dp.pc_inc   = 1'b0;
        dp.pc_load  = 1'b0;
        dp.ir_load  = 1'b0;
        dp.mar_load = 1'b0;
        dp.mar_src  = 1'b0;
        dp.mdr_load = 1'b0;
        dp.mdr_src  = 1'b0;
        dp.acc_load = 1'b0;
        dp.alu_op   = ALU_PASS;
        dp.mem_we   = 1'b0;
        dp.div_load = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH1: dp.mar_load = 1'b1;
                S_FETCH2: dp.mdr_load = 1'b1;
                S_FETCH3: begin
                    dp.ir_load = 1'b1;
                    dp.pc_inc  = 1'b1;
                end
                S_DECODE: begin
                    case (dp.opcode)
                        OP_NOT: begin
                            dp.acc_load = 1'b1;
                            dp.alu_op   = ALU_NOT;
                        end
                        OP_JMP: dp.pc_load = 1'b1;
                        OP_JZ:  dp.pc_load = dp.zflag;
                        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_DIV, OP_STORE: begin
                            dp.mar_load = 1'b1;
                            dp.mar_src  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEMRD: dp.mdr_load = 1'b1;
                S_EXEC: begin
                    dp.acc_load = 1'b1;
                    case (dp.opcode)
                        OP_ADD:  dp.alu_op = ALU_ADD;
                        OP_SUB:  dp.alu_op = ALU_SUB;
                        OP_AND:  dp.alu_op = ALU_AND;
                        OP_OR:   dp.alu_op = ALU_OR;
                        default: dp.alu_op = ALU_PASS;
                    endcase
                end
                S_ST1: begin
                    dp.mdr_load = 1'b1;
                    dp.mdr_src  = 1'b1;
                end
                S_ST2:       dp.mem_we   = 1'b1;
                S_DIV_START: dp.div_load = 1'b1;
                S_DIV_WAIT: begin
                    if (div_seen) begin
                        dp.acc_load = 1'b1;
                        dp.alu_op   = ALU_DIVQ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted  = (state == S_HALT);
    assign state_o = state;

endmodule

// File: tb/tb_proj1_ctrl.sv
// Directed bench: main DUT runs small programs on a behavioural datapath,
// a second DUT (DIV_TIMEOUT=8) is driven directly for divider/illegal cases.
module tb_proj1_ctrl;
    localparam logic [3:0] ST_F1 = 4'd0, ST_F2 = 4'd1, ST_DEC = 4'd3, ST_ST2 = 4'd7;
    localparam logic [3:0] ST_DWAIT = 4'd9, ST_HALT = 4'd10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, run = 1'b0, rst_t = 1'b1, run_t = 1'b0;
    logic halted, illegal, div_err, halted_t, illegal_t, div_err_t;
    logic [15:0] icount, icount_t;
    logic [3:0]  m_state, t_state;

    proj1_ctrl_if m_if ();
    proj1_ctrl_if t_if ();

    proj1_ctrl u_dut (
        .clk(clk), .rst(rst), .dp(m_if.master), .run(run), .halted(halted),
        .illegal(illegal), .div_err(div_err), .instr_count(icount), .state_o(m_state)
    );

    proj1_ctrl #(.DIV_TIMEOUT(8)) u_dut_t (
        .clk(clk), .rst(rst_t), .dp(t_if.master), .run(run_t), .halted(halted_t),
        .illegal(illegal_t), .div_err(div_err_t), .instr_count(icount_t), .state_o(t_state)
    );

    // Behavioural datapath and divider for the main DUT
    logic [7:0]  pc, mar;
    logic [15:0] ir, mdr, acc, dq;
    logic [15:0] mem [256];
    logic        dv_done, dv_busy;
    logic [3:0]  dcnt;

    assign m_if.opcode   = ir[15:12];
    assign m_if.zflag    = (acc == 16'd0);
    assign m_if.div_done = dv_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0; ir <= '0; mar <= '0; mdr <= '0; acc <= '0;
        end else begin
            if (m_if.pc_load)      pc <= ir[7:0];
            else if (m_if.pc_inc)  pc <= pc + 8'd1;
            if (m_if.ir_load)  ir  <= mdr;
            if (m_if.mar_load) mar <= m_if.mar_src ? ir[7:0] : pc;
            if (m_if.mdr_load) mdr <= m_if.mdr_src ? acc : mem[mar];
            if (m_if.acc_load) begin
                case (m_if.alu_op)
                    3'd0: acc <= mdr;
                    3'd1: acc <= acc + mdr;
                    3'd2: acc <= acc - mdr;
                    3'd3: acc <= acc & mdr;
                    3'd4: acc <= acc | mdr;
                    3'd5: acc <= ~acc;
                    3'd6: acc <= dq;
                    default: acc <= acc;
                endcase
            end
        end
    end

    // Done rises on the 9th edge after the edge that samples Load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_done <= 1'b0; dv_busy <= 1'b0; dcnt <= '0; dq <= '0;
        end else if (m_if.div_load) begin
            dv_done <= 1'b0; dv_busy <= 1'b1; dcnt <= '0;
            dq <= (mdr == 16'd0) ? 16'hFFFF : acc / mdr;
        end else if (dv_busy) begin
            if (dcnt == 4'd8) begin
                dv_done <= 1'b1; dv_busy <= 1'b0;
            end else begin
                dcnt <= dcnt + 4'd1;
            end
        end
    end

    int n_checks = 0, n_pass = 0;
    int n_we, n_we_st2, n_pcl, n_pcl_dec, n_accl, n_acc_div, n_divl, n_dwait;
    int n_dec_mar, n_bad_src, n_excl;
    logic [7:0]  we_addr;
    logic [15:0] we_data;

    task automatic clear_mon();
        n_we = 0; n_we_st2 = 0; n_pcl = 0; n_pcl_dec = 0; n_accl = 0; n_acc_div = 0;
        n_divl = 0; n_dwait = 0; n_dec_mar = 0; n_bad_src = 0; n_excl = 0;
        we_addr = '0; we_data = '0;
    endtask

    task automatic sample_m();
        if (m_if.mem_we) begin
            n_we++; if (m_state == ST_ST2) n_we_st2++;
            we_addr = mar; we_data = mdr;
        end
        if (m_if.pc_load) begin n_pcl++; if (m_state == ST_DEC) n_pcl_dec++; end
        if (m_if.acc_load) n_accl++;
        if (m_if.acc_load && m_if.alu_op == 3'd6 && dv_done) n_acc_div++;
        if (m_if.div_load) n_divl++;
        if (m_state == ST_DWAIT) n_dwait++;
        if (m_state == ST_DEC && m_if.mar_load) begin
            n_dec_mar++; if (!m_if.mar_src) n_bad_src++;
        end
        if ((m_if.pc_inc && m_if.pc_load) || (m_if.mem_we && m_if.mdr_load)) n_excl++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic reset_main();
        rst = 1'b0; run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_mon();
        sample_m();
    endtask

    task automatic run_main(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            @(posedge clk); #1;
            cyc++;
            sample_m();
        end
    endtask

    task automatic reset_t();
        rst_t = 1'b0; run_t = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_t = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] strobes;
        clear_mem();
        t_if.opcode = 4'h0; t_if.zflag = 1'b0; t_if.div_done = 1'b0;
        #2; rst = 1'b0; rst_t = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        strobes = {m_if.pc_inc, m_if.pc_load, m_if.ir_load, m_if.mar_load, m_if.mar_src,
                   m_if.mdr_load, m_if.mdr_src, m_if.acc_load, m_if.alu_op, m_if.mem_we, m_if.div_load};
        n_checks++; if (m_state !== ST_F1) $display("FAIL rst_state: got %0d want 0", m_state); else n_pass++;
        n_checks++; if (strobes !== 14'd0) $display("FAIL rst_strobes: got %0h want 0", strobes); else n_pass++;
        n_checks++; if ({halted, illegal, div_err} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {halted, illegal, div_err}); else n_pass++;
        n_checks++; if (icount !== 16'd0) $display("FAIL rst_icount: got %0d want 0", icount); else n_pass++;
        rst = 1'b1; rst_t = 1'b1;
        #1;
        n_checks++; if (m_if.mar_load !== 1'b1 || m_state !== ST_F1) $display("FAIL t0_fetch1: got state %0d mar_load %b want 0/1", m_state, m_if.mar_load); else n_pass++;
    endtask

    task automatic test_nop_halt();
        int cyc;
        clear_mem();
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hF000;
        reset_main();
        n_checks++; if (m_state !== ST_F1) $display("FAIL nop_t0: got %0d want 0", m_state); else n_pass++;
        run_main(40, cyc);
        n_checks++; if (cyc !== 12) $display("FAIL nop_cycles: got %0d want 12", cyc); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL nop_halted: got %b want 1", halted); else n_pass++;
        n_checks++; if (icount !== 16'd3) $display("FAIL nop_icount: got %0d want 3", icount); else n_pass++;
        n_checks++; if (n_we !== 0) $display("FAIL nop_mem_we: got %0d want 0", n_we); else n_pass++;
    endtask

    task automatic test_load_add_store();
        int cyc;
        clear_mem();
        mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h2012; mem[3] = 16'hF000;
        mem[8'h10] = 16'h0005; mem[8'h11] = 16'h0003;
        reset_main();
        run_main(60, cyc);
        n_checks++; if (cyc !== 22) $display("FAIL las_cycles: got %0d want 22", cyc); else n_pass++;
        n_checks++; if (we_addr !== 8'h12 || we_data !== 16'h0008) $display("FAIL las_store: got [%0h]=%0h want [12]=8", we_addr, we_data); else n_pass++;
        n_checks++; if (n_we !== 1 || n_we_st2 !== 1) $display("FAIL las_mem_we: got %0d/%0d in ST2 want 1/1", n_we, n_we_st2); else n_pass++;
        n_checks++; if (n_dec_mar !== 3 || n_bad_src !== 0) $display("FAIL las_mar_src: got %0d loads %0d bad want 3/0", n_dec_mar, n_bad_src); else n_pass++;
        n_checks++; if (n_excl !== 0) $display("FAIL las_exclusion: got %0d want 0", n_excl); else n_pass++;
        n_checks++; if (icount !== 16'd4) $display("FAIL las_icount: got %0d want 4", icount); else n_pass++;
    endtask

    task automatic test_jz();
        int cyc;
        clear_mem();
        mem[0] = 16'h1010; mem[1] = 16'h9020; mem[2] = 16'hF000;
        mem[8'h10] = 16'h0005; mem[8'h20] = 16'hB000;
        reset_main();
        run_main(40, cyc);
        n_checks++; if (cyc !== 14) $display("FAIL jz0_cycles: got %0d want 14", cyc); else n_pass++;
        n_checks++; if (n_pcl !== 0) $display("FAIL jz0_pc_load: got %0d want 0", n_pcl); else n_pass++;

        clear_mem();
        mem[0] = 16'h1013; mem[1] = 16'h9020; mem[2] = 16'hB000;
        mem[8'h13] = 16'h0000; mem[8'h20] = 16'hF000;
        reset_main();
        run_main(40, cyc);
        n_checks++; if (cyc !== 14) $display("FAIL jz1_cycles: got %0d want 14", cyc); else n_pass++;
        n_checks++; if (n_pcl !== 1 || n_pcl_dec !== 1) $display("FAIL jz1_pc_load: got %0d/%0d in DECODE want 1/1", n_pcl, n_pcl_dec); else n_pass++;
        n_checks++; if (illegal !== 1'b0 || pc !== 8'h21) $display("FAIL jz1_target: got illegal %b pc %0h want 0/21", illegal, pc); else n_pass++;
    endtask

    task automatic test_div();
        int cyc;
        clear_mem();
        mem[0] = 16'h1014; mem[1] = 16'hA015; mem[2] = 16'hF000;
        mem[8'h14] = 16'd20; mem[8'h15] = 16'd4;
        reset_main();
        run_main(80, cyc);
        n_checks++; if (cyc !== 26) $display("FAIL div_cycles: got %0d want 26", cyc); else n_pass++;
        n_checks++; if (n_divl !== 1) $display("FAIL div_load: got %0d want 1", n_divl); else n_pass++;
        n_checks++; if (n_dwait !== 10) $display("FAIL div_wait_len: got %0d want 10", n_dwait); else n_pass++;
        n_checks++; if (n_acc_div !== 1 || n_accl !== 2) $display("FAIL div_acc_load: got %0d divq %0d total want 1/2", n_acc_div, n_accl); else n_pass++;
        n_checks++; if (acc !== 16'd5 || div_err !== 1'b0) $display("FAIL div_result: got acc %0d err %b want 5/0", acc, div_err); else n_pass++;
    endtask

    task automatic test_div_timeout();
        int cyc, tw, ta;
        t_if.opcode = 4'hA; t_if.div_done = 1'b0;
        reset_t();
        cyc = 0; tw = 0; ta = 0;
        while (!halted_t && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (t_state == ST_DWAIT) tw++;
            if (t_if.acc_load) ta++;
        end
        n_checks++; if (cyc !== 14) $display("FAIL tmo_cycles: got %0d want 14", cyc); else n_pass++;
        n_checks++; if (tw !== 8) $display("FAIL tmo_wait_len: got %0d want 8", tw); else n_pass++;
        n_checks++; if (ta !== 0) $display("FAIL tmo_acc_load: got %0d want 0", ta); else n_pass++;
        n_checks++; if ({halted_t, div_err_t, illegal_t} !== 3'b110) $display("FAIL tmo_flags: got %b want 110", {halted_t, div_err_t, illegal_t}); else n_pass++;
        run_t = 1'b1;
        @(posedge clk); #1;
        run_t = 1'b0;
        n_checks++; if (t_state !== ST_F1 || div_err_t !== 1'b0 || halted_t !== 1'b0) $display("FAIL tmo_run: got state %0d err %b halted %b want 0/0/0", t_state, div_err_t, halted_t); else n_pass++;
        run_t = 1'b1;
        @(posedge clk); #1;
        run_t = 1'b0;
        n_checks++; if (t_state !== ST_F2) $display("FAIL run_ignored: got %0d want 1", t_state); else n_pass++;
    endtask

    task automatic test_div_first_cycle();
        int cyc;
        t_if.opcode = 4'hA; t_if.div_done = 1'b1;
        reset_t();
        cyc = 0;
        while (t_state !== ST_DWAIT && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (cyc !== 6 || t_if.acc_load !== 1'b0) $display("FAIL first_wait_ignored: got cyc %0d acc_load %b want 6/0", cyc, t_if.acc_load); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (t_if.acc_load !== 1'b1 || t_if.alu_op !== 3'd6) $display("FAIL done_acc_load: got %b op %0d want 1/6", t_if.acc_load, t_if.alu_op); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (t_state !== ST_F1) $display("FAIL done_to_fetch: got %0d want 0", t_state); else n_pass++;
        t_if.div_done = 1'b0;
    endtask

    task automatic test_illegal_and_reset();
        int cyc;
        t_if.opcode = 4'hC; t_if.div_done = 1'b0;
        reset_t();
        cyc = 0;
        while (!halted_t && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (cyc !== 4) $display("FAIL ill_cycles: got %0d want 4", cyc); else n_pass++;
        n_checks++; if ({illegal_t, halted_t, div_err_t} !== 3'b110) $display("FAIL ill_flags: got %b want 110", {illegal_t, halted_t, div_err_t}); else n_pass++;
        n_checks++; if (icount_t !== 16'd1) $display("FAIL ill_icount: got %0d want 1", icount_t); else n_pass++;
        t_if.opcode = 4'hA;
        run_t = 1'b1;
        @(posedge clk); #1;
        run_t = 1'b0;
        n_checks++; if (illegal_t !== 1'b0 || t_state !== ST_F1) $display("FAIL ill_run_clear: got illegal %b state %0d want 0/0", illegal_t, t_state); else n_pass++;
        cyc = 0;
        while (t_state !== ST_DWAIT && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (t_state !== ST_DWAIT || icount_t !== 16'd2) $display("FAIL mid_wait_setup: got state %0d icount %0d want 9/2", t_state, icount_t); else n_pass++;
        #1;
        rst_t = 1'b0;
        #1;
        n_checks++; if (t_state !== ST_F1 || icount_t !== 16'd0) $display("FAIL async_rst_state: got state %0d icount %0d want 0/0", t_state, icount_t); else n_pass++;
        n_checks++; if ({halted_t, illegal_t, div_err_t, t_if.div_load, t_if.acc_load, t_if.mar_load} !== 6'd0) $display("FAIL async_rst_flags: got %b want 000000", {halted_t, illegal_t, div_err_t, t_if.div_load, t_if.acc_load, t_if.mar_load}); else n_pass++;
        @(negedge clk);
        rst_t = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nop_halt();
        test_load_add_store();
        test_jz();
        test_div();
        test_div_timeout();
        test_div_first_cycle();
        test_illegal_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/proj1_ctrl.md
Name: proj1_ctrl

Overview:
Moore-style control unit that sequences the accumulator datapath: the PC/IR/ACC/MDR/MAR register bank, the 256x16 RAM and the iterative 16-bit divider.
- Runs the fetch/decode/execute loop.
- Drives every register load enable, the mux selects, the ALU op and the memory write strobe.
- Handshakes with the divider through Load/Done and guards that wait with a timeout.
- Sits in the top level between the IR/Zflag outputs and the datapath enables.

Parameters:
DIV_TIMEOUT, 64, maximum DIV_WAIT cycles before div_err halt (2..255)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  4  IR[15:12] from the register bank
zflag  in  1  Zflag_reg (ACC == 0)
div_done  in  1  divider Done
run  in  1  restart request, honoured only in HALT
pc_inc  out  1  PC <= PC+1 (wraps 8'hFF->8'h00)
pc_load  out  1  PC <= IR[7:0]
ir_load  out  1  IR <= MDR
mar_load  out  1  MAR <= selected source
mar_src  out  1  0 = PC, 1 = IR[7:0]
mdr_load  out  1  MDR <= selected source
mdr_src  out  1  0 = RAM q, 1 = ACC
acc_load  out  1  ACC <= ALU result
alu_op  out  3  0 PASS(MDR), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT(ACC), 6 DIVQ (divider Q)
mem_we  out  1  RAM write strobe (MemRW_IO)
div_load  out  1  divider Load
halted  out  1  high while in HALT
illegal  out  1  sticky: halted on an undefined opcode
div_err  out  1  sticky: halted on divider timeout
instr_count  out  CNT_W  retired instruction count, wraps
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH1.
  - instr_count=0; illegal=0; div_err=0; halted=0.
  - All strobes and selects 0; alu_op=0.
- Strobe timing: all strobes are decoded from the current state, plus opcode/zflag where noted. Each strobe is high for exactly one cycle per state visit.
- Opcodes:
  - 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT, 8 JMP, 9 JZ, A DIV, F HALT.
  - B-E are illegal.
- States and transitions:
  - FETCH1: mar_load, mar_src=0 -> FETCH2.
  - FETCH2: mdr_load, mdr_src=0 -> FETCH3.
  - FETCH3: ir_load, pc_inc, instr_count+1 -> DECODE.
  - DECODE, by opcode:
    - NOP -> FETCH1.
    - NOT: acc_load, alu_op=5 -> FETCH1.
    - JMP: pc_load -> FETCH1.
    - JZ: pc_load = zflag -> FETCH1.
    - LOAD/ADD/SUB/AND/OR/DIV: mar_load, mar_src=1 -> MEMRD.
    - STORE: mar_load, mar_src=1 -> ST1.
    - HALT -> HALT.
    - Illegal: illegal<=1 -> HALT.
  - MEMRD: mdr_load, mdr_src=0 -> EXEC, or DIV_START for DIV.
  - EXEC: acc_load, alu_op = PASS/ADD/SUB/AND/OR per opcode -> FETCH1.
  - ST1: mdr_load, mdr_src=1 -> ST2.
  - ST2: mem_we -> FETCH1.
  - DIV_START: div_load for exactly one cycle; timeout counter cleared -> DIV_WAIT.
  - DIV_WAIT:
    - First cycle: div_done is ignored, because the divider clears Done on the edge it samples Load.
    - After that, div_done=1 gives acc_load, alu_op=6 -> FETCH1.
    - Otherwise the counter increments. When it reaches DIV_TIMEOUT-1: div_err<=1 -> HALT, with no ACC write.
  - HALT:
    - halted=1; all strobes 0.
    - run=1 clears illegal and div_err -> FETCH1.
    - run in any other state is ignored.
- Latency, fetch to next FETCH1:
  - NOP, NOT, JMP, JZ: 4 cycles.
  - LOAD, ALU ops, STORE: 6 cycles.
  - DIV: 6 cycles + divider time + 1.
- Counter widths: instr_count wraps at 2^CNT_W. The timeout counter is 8 bits.
- Instruction count: HALT and illegal opcodes still count, because they were fetched.
- Mutual exclusion: pc_inc and pc_load never assert together; mem_we and mdr_load never assert together.
- Reset mid-instruction (including DIV_WAIT): immediate return to FETCH1 with the flags cleared. The divider is reset separately by the top level.

Test Plan:
- Reset, then program NOP,NOP,HALT -> FETCH1 at t0; halted=1 after 12 cycles; instr_count=3; no mem_we seen.
- LOAD 0x10 (MEM[0x10]=0x0005), then ADD 0x11 (=0x0003), then STORE 0x12, then HALT -> MEM[0x12]=0x0008; mar_src=1 in each DECODE; mem_we exactly one cycle, in ST2.
- JZ 0x20 with zflag=0 -> pc_load never high; repeat with zflag=1 -> pc_load one cycle in DECODE.
- DIV with the divider model asserting Done 9 cycles after Load -> div_load one cycle; acc_load with alu_op=6 in the cycle Done is seen; no div_err.
- DIV with div_done stuck 0 and DIV_TIMEOUT=8 -> HALT after 8 DIV_WAIT cycles; div_err=1; acc_load never asserted; run pulse returns to FETCH1 with div_err=0.
- Opcode 0xC -> illegal=1, halted=1; drop rst mid-DIV_WAIT -> state_o=FETCH1 and all flags 0 without waiting for a clock edge.
